morse_transmitter: RTL and testbench



---
 rtl/morse_transmitter.sv | 172 +++++++++++++++++
 tb/tb_morse_transmitter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/morse_transmitter.sv
// ---------------------------------------------------------------------------
// morse_transmitter
//   Plays one latched Morse letter (up to four elements) on a single lamp
//   output with standard timing: dot = 1 unit on, dash = 3 units on,
//   1 unit off between elements, 3 units off after the letter.
//
//   state | meaning
//   ------+--------------------------------------------
//   IDLE  | waiting for START, all outputs low
//   MARK  | lamp on for the current element (1 or 3 units)
//   SPACE | 1-unit gap between elements
//   LGAP  | 3-unit trailing letter gap, DONE on last cycle
//
// Parameters:
//   UNIT_CYCLES  clock cycles per Morse time unit (>= 1)
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   START    in   transmit request, honoured only when idle
//   PATTERN  in   [3:0] elements MSB first, 0 = dot, 1 = dash
//   LEN      in   [2:0] element count, 0..4 (5..7 treated as 4)
//   LEDR     out  lamp output
//   BUSY     out  high while a letter (including trailing gap) is in progress
//   DONE     out  one-cycle pulse on the final cycle of the letter gap
// Build option:
//   MORSE_START_EDGE_EN  when defined, START is an asynchronous key level:
//                        it is synchronised (2 flops) and only its rising
//                        edge starts a letter.
// ---------------------------------------------------------------------------
module morse_transmitter #(
  parameter int UNIT_CYCLES = 25_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] PATTERN,
  input  logic [2:0] LEN,
  output logic       LEDR,
  output logic       BUSY,
  output logic       DONE
);

  localparam int CW = $clog2(3 * UNIT_CYCLES) + 1;
  localparam logic [CW-1:0] U1_LOAD = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] U3_LOAD = CW'(3 * UNIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MARK  = 2'd1;
  localparam logic [1:0] S_SPACE = 2'd2;
  localparam logic [1:0] S_LGAP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    shift_q, shift_d;
  logic [2:0]    elem_q, elem_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_req;
  logic          launch;
  logic [2:0]    len_clamp;

`ifdef MORSE_START_EDGE_EN
  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= START;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign start_req = sync2_q & ~sync3_q;
`else
  assign start_req = START;
`endif

  assign len_clamp = LEN[2] ? 3'd4 : LEN;

  // The final LGAP cycle doubles as an accept slot so letters can run
  // back to back without an idle cycle in between.
  assign launch = start_req &&
                  ((state_q == S_IDLE) || (state_q == S_LGAP && cnt_q == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    elem_d  = elem_q;

    case (state_q)
      S_MARK: begin
        if (cnt_q == '0) begin
          shift_d = {shift_q[2:0], 1'b0};
          elem_d  = elem_q - 3'd1;
          if (elem_q != 3'd1) begin
            state_d = S_SPACE;
            cnt_d   = U1_LOAD;
          end else begin
            state_d = S_LGAP;
            cnt_d   = U3_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SPACE: begin
        if (cnt_q == '0) begin
          state_d = S_MARK;
          cnt_d   = shift_q[3] ? U3_LOAD : U1_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LGAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase

    if (launch) begin
      if (len_clamp == 3'd0) begin
        state_d = S_LGAP;
        cnt_d   = U3_LOAD;
      end else begin
        state_d = S_MARK;
        shift_d = PATTERN;
        elem_d  = len_clamp;
        cnt_d   = PATTERN[3] ? U3_LOAD : U1_LOAD;
      end
    end

    // Outputs are registered from the next state so they line up with it.
    led_d  = (state_d == S_MARK);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_LGAP) && (cnt_d == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      elem_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      elem_q  <= elem_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign LEDR = led_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_morse_transmitter.sv
module tb_morse_transmitter;

  localparam int U = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [3:0] PATTERN = 4'd0;
  logic [2:0] LEN = 3'd0;
  logic       LEDR, BUSY, DONE;

  morse_transmitter #(.UNIT_CYCLES(U)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PATTERN(PATTERN), .LEN(LEN),
    .LEDR(LEDR), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int errors = 0;
  int letters = 0;

  // Scoreboard: expected lamp trace per letter, one bit per BUSY cycle.
  int exp_len[$];
  bit exp_bits[$];
  bit cur[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: Morse timing rules expanded into a per-cycle lamp trace.
  task automatic expect_letter(input logic [3:0] p, input int len);
    int n;
    int total;
    n = (len > 4) ? 4 : len;
    total = 0;
    for (int i = 0; i < n; i++) begin
      int d;
      d = p[3-i] ? 3 * U : U;
      for (int k = 0; k < d; k++) exp_bits.push_back(1'b1);
      total += d;
      if (i < n - 1) begin
        for (int k = 0; k < U; k++) exp_bits.push_back(1'b0);
        total += U;
      end
    end
    for (int k = 0; k < 3 * U; k++) exp_bits.push_back(1'b0);
    total += 3 * U;
    exp_len.push_back(total);
  endtask

  // Monitor
  int m_len, m_diff;
  bit m_b;
  always @(negedge CLK) begin
    if (RST) begin
      cur.delete();
    end else if (BUSY) begin
      cur.push_back(LEDR);
      if (DONE) begin
        if (exp_len.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          m_len = exp_len.pop_front();
          chk("busy_len", cur.size(), m_len);
          m_diff = -1;
          for (int i = 0; i < m_len; i++) begin
            m_b = exp_bits.pop_front();
            if (m_diff < 0 && (i >= cur.size() || cur[i] != m_b)) m_diff = i;
          end
          chk("trace_first_diff", m_diff, -1);
        end
        letters++;
        cur.delete();
      end
    end else begin
      chk("idle_ledr", int'(LEDR), 0);
      chk("idle_done", int'(DONE), 0);
      if (cur.size() != 0) begin
        chk("busy_fell_without_done", cur.size(), 0);
        cur.delete();
      end
    end
  end

  task automatic send(input logic [3:0] p, input logic [2:0] l);
    @(negedge CLK);
    PATTERN = p;
    LEN = l;
    START = 1'b1;
    expect_letter(p, int'(l));
    @(posedge CLK);
    #1 START = 1'b0;
`ifdef MORSE_START_EDGE_EN
    repeat (2) @(posedge CLK);
    #1;
`endif
    chk("start_busy", int'(BUSY), 1);
    chk("start_ledr", int'(LEDR), (l != 3'd0) ? 1 : 0);
    PATTERN = 4'($urandom);
    LEN = 3'($urandom);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge CLK);
      if (!BUSY) seen = 1'b1;
    end
    chk("wait_idle_timeout", int'(seen), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("reset_ledr", int'(LEDR), 0);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_done", int'(DONE), 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Letter A, letter H
    send(4'b0100, 3'd2); wait_idle();
    send(4'b0000, 3'd4); wait_idle();
    // LEN = 0 then LEN = 7 clamped
    send(4'b1010, 3'd0); wait_idle();
    send(4'b1111, 3'd7); wait_idle();

    // Letter B with a mid-letter START carrying a different pattern
    send(4'b1000, 3'd4);
    repeat (10) @(negedge CLK);
    PATTERN = 4'b1111; LEN = 3'd2; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_idle();

    // Reset in the middle of a dash
    send(4'b1000, 3'd1);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("abort_ledr", int'(LEDR), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    exp_len.delete();
    exp_bits.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    send(4'b0110, 3'd3); wait_idle();

    // Randomized letters with random idle gaps
    for (int n = 0; n < 16; n++) begin
      send(4'($urandom), 3'($urandom_range(0, 7)));
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end

    // START held high for 200 edges, letter E (one dot, 16 busy cycles)
    @(negedge CLK);
    PATTERN = 4'b0000; LEN = 3'd1; START = 1'b1;
`ifdef MORSE_START_EDGE_EN
    expect_letter(4'b0000, 1);
    repeat (2) @(posedge CLK);
    #1 chk("edge_latency_early", int'(LEDR), 0);
    @(posedge CLK);
    #1 chk("edge_latency_ledr", int'(LEDR), 1);
    repeat (197) @(posedge CLK);
`else
    for (int n = 0; n * 16 <= 199; n++) expect_letter(4'b0000, 1);
    repeat (200) @(posedge CLK);
`endif
    @(negedge CLK);
    START = 1'b0;
    wait_idle();
    repeat (4) @(negedge CLK);

    chk("pending_letters", exp_len.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
